// File: rtl/smac_ctrl_pkg.sv
// smac_ctrl_pkg: shared types and constants for the SMAC sequencing FSM.
//   state_e       - controller state encoding
//   TO_W          - width of the wait-state timeout counter
//   is_wait_state - states in which the timeout counter runs
package smac_ctrl_pkg;

  localparam int TO_W = 10;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CFG  = 4'd1,
    LDW  = 4'd2,
    MAC  = 4'd3,
    STEP = 4'd4,
    ACC3 = 4'd5,
    CLRS = 4'd6,
    QNT  = 4'd7,
    WB   = 4'd8,
    NXT  = 4'd9,
    FIN  = 4'd10
  } state_e;

  function automatic logic is_wait_state(input state_e s);
    return (s == LDW) || (s == MAC) || (s == QNT) || (s == WB);
  endfunction

endpackage

// File: rtl/smac_ctrl_if.sv
// smac_ctrl_if: groups the host handshake, counter status flags and
// counter/datapath strobes of the SMAC controller.
//   master - the controller (drives busy/done/error and all strobes)
//   slave  - host + counter top level (drives start/abort and status flags)
interface smac_ctrl_if;
  // host handshake
  logic start, abort, busy, done, error;
  // status flags from the counter top level
  logic cnt_sr_w7, bit_m, term_ac1, term_ac2, remW, done_quant, relu_done, op_done;
  // strobes to the counters / datapath
  logic cnt_load, cnt_clear_start, cnt_clear_finish, cnt_clear_vol;
  logic wei_load, w_en_w, w_and_s_ac1, valid_ac2, valid_ac3, act_wb, cnt_in_vol;

  modport master (
    input  start, abort, cnt_sr_w7, bit_m, term_ac1, term_ac2, remW,
           done_quant, relu_done, op_done,
    output busy, done, error, cnt_load, cnt_clear_start, cnt_clear_finish,
           cnt_clear_vol, wei_load, w_en_w, w_and_s_ac1, valid_ac2,
           valid_ac3, act_wb, cnt_in_vol
  );

  modport slave (
    output start, abort, cnt_sr_w7, bit_m, term_ac1, term_ac2, remW,
           done_quant, relu_done, op_done,
    input  busy, done, error, cnt_load, cnt_clear_start, cnt_clear_finish,
           cnt_clear_vol, wei_load, w_en_w, w_and_s_ac1, valid_ac2,
           valid_ac3, act_wb, cnt_in_vol
  );
endinterface

// File: rtl/smac_ctrl_timeout.sv
// smac_ctrl_timeout: wait-state cycle counter.
//   clk, rst_n - clock, async active-low reset
//   clr        - restart counting from zero (state change)
//   en         - count this cycle (FSM is in a wait state)
//   tc         - counter holds TC_VAL-1, i.e. this is the TC_VAL-th wait cycle
module smac_ctrl_timeout
  import smac_ctrl_pkg::*;
#(
  parameter int TC_VAL = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TO_W-1:0] TC_LAST = TO_W'(TC_VAL - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc = en && (cnt_q == TC_LAST);

endmodule

// File: rtl/smac_ctrl_fsm.sv
// smac_ctrl_fsm: main sequencing FSM of the SMAC engine. Walks one layer
// through weight load -> bit-serial MAC -> AC2/AC3 accumulate -> quantize
// -> ReLU write-back -> next volume.
//   clk, rst_n  - clock, async active-low reset
//   bus         - smac_ctrl_if.master: start/abort/busy/done/error, counter
//                 status flags in, counter/datapath strobes out
//   perf_cycles - busy-cycle count of the current layer (only when
//                 SMAC_CTRL_PERF_EN is defined)
// All outputs are decoded from registered state only.
module smac_ctrl_fsm
  import smac_ctrl_pkg::*;
#(
  parameter int Pw         = 4,
  parameter int Pa         = 8,
  parameter int WB_TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  smac_ctrl_if.master  bus
`ifdef SMAC_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_cycles
`endif
);

  state_e state_q, state_d;
  logic   error_q, error_d;
  // Set when the FSM was forced back to IDLE (abort/timeout); the counter
  // clears are then issued from IDLE so they stay a function of state.
  logic   clr_pend_q, clr_pend_d;
  logic   to_tc;

  smac_ctrl_timeout #(.TC_VAL(WB_TIMEOUT)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_d != state_q),
    .en    (is_wait_state(state_q)),
    .tc    (to_tc)
  );

  // ---------------- next state ----------------
  always_comb begin
    state_d    = state_q;
    error_d    = error_q;
    clr_pend_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
              state_d = CFG;
              error_d = 1'b0;
            end
      CFG:  state_d = LDW;
      LDW:  if (bus.cnt_sr_w7)  state_d = MAC;
      MAC:  if (bus.term_ac1)   state_d = STEP;
      STEP: state_d = (bus.term_ac2 || bus.bit_m) ? ACC3 : MAC;
      ACC3: state_d = bus.remW ? CLRS : QNT;
      CLRS: state_d = LDW;
      QNT:  if (bus.done_quant) state_d = WB;
      WB:   if (bus.relu_done)  state_d = NXT;
      NXT:  state_d = bus.op_done ? FIN : CLRS;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (to_tc) begin
      state_d    = IDLE;
      error_d    = 1'b1;
      clr_pend_d = 1'b1;
    end
    // abort outranks everything, including a start or a timeout
    if (bus.abort) begin
      state_d    = IDLE;
      error_d    = error_q;
      clr_pend_d = (state_q != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      error_q    <= 1'b0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      error_q    <= error_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // ---------------- Moore output decode ----------------
  logic o_load, o_cs, o_cf, o_cv, o_wei, o_wen, o_was, o_v2, o_v3, o_wb, o_vol;

  always_comb begin
    o_load = 1'b0; o_cs = 1'b0; o_cf = 1'b0; o_cv  = 1'b0;
    o_wei  = 1'b0; o_wen = 1'b0; o_was = 1'b0; o_v2 = 1'b0;
    o_v3   = 1'b0; o_wb  = 1'b0; o_vol = 1'b0;
    case (state_q)
      IDLE: begin o_cs = clr_pend_q; o_cf = clr_pend_q; o_cv = clr_pend_q; end
      CFG:  begin o_load = 1'b1; o_cs = 1'b1; o_cf = 1'b1; o_cv = 1'b1; end
      LDW:  o_wei = 1'b1;
      MAC:  o_was = 1'b1;
      STEP: begin o_wen = 1'b1; o_v2 = 1'b1; end
      ACC3: o_v3 = 1'b1;
      CLRS: o_cs = 1'b1;
      WB:   o_wb = 1'b1;
      NXT:  begin o_vol = 1'b1; o_cf = 1'b1; end
      FIN:  o_cv = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy             = (state_q != IDLE);
  assign bus.done             = (state_q == FIN);
  assign bus.error            = error_q;
  assign bus.cnt_load         = o_load;
  assign bus.cnt_clear_start  = o_cs;
  assign bus.cnt_clear_finish = o_cf;
  assign bus.cnt_clear_vol    = o_cv;
  assign bus.wei_load         = o_wei;
  assign bus.w_en_w           = o_wen;
  assign bus.w_and_s_ac1      = o_was;
  assign bus.valid_ac2        = o_v2;
  assign bus.valid_ac3        = o_v3;
  assign bus.act_wb           = o_wb;
  assign bus.cnt_in_vol       = o_vol;

`ifdef SMAC_CTRL_PERF_EN
  // Counts CFG..NXT; FIN and IDLE hold the value until the next accepted start.
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == IDLE && bus.start && !bus.abort)
      perf_d = '0;
    else if (state_q != IDLE && state_q != FIN && perf_q != 32'hFFFF_FFFF)
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

`ifndef SYNTHESIS
  // A filter group never needs more w_en_w steps than weight x activation bits.
  logic [15:0] wen_cnt_q, wen_cnt_d;

  always_comb begin
    wen_cnt_d = wen_cnt_q;
    if (state_q == CFG || state_q == CLRS) wen_cnt_d = '0;
    else if (o_wen)                        wen_cnt_d = wen_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wen_cnt_q <= '0;
    else begin
      wen_cnt_q <= wen_cnt_d;
      assert (32'(wen_cnt_q) <= Pw * Pa)
        else $error("w_en_w pulse count %0d exceeds Pw*Pa", wen_cnt_q);
    end
  end
`endif

endmodule
